// File: rtl/rotate_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rotate_pkg
// Purpose  : Shared widths, the quarter-turn offset and the state encoding
//            for the rotation-coefficient sequencer.
// Contents : ANGLE_W, COEF_W, QUARTER, state constants, state_t
// Revision : 1.0 - initial release
// ============================================================================
package rotate_pkg;

   localparam int ANGLE_W = 8;     // 256 angle steps per full turn
   localparam int COEF_W  = 18;    // signed ROM word
   localparam int QUARTER = 64;    // 90 degrees in angle steps

   // Sequencer state encoding
   localparam logic [2:0] c_st_idle     = 3'd0;
   localparam logic [2:0] c_st_addr_cos = 3'd1;
   localparam logic [2:0] c_st_addr_sin = 3'd2;
   localparam logic [2:0] c_st_wait     = 3'd3;
   localparam logic [2:0] c_st_cap_sin  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE     = c_st_idle,
      ST_ADDR_COS = c_st_addr_cos,
      ST_ADDR_SIN = c_st_addr_sin,
      ST_WAIT     = c_st_wait,
      ST_CAP_SIN  = c_st_cap_sin
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter. A lone requester is granted
//            directly; on a tie the requester not granted last time wins.
//            The last-grant pointer resets to 1 so requester 0 wins the
//            first tie, and only moves when the grant is consumed.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            req[1:0]      - request vector
//            advance       - the current grant was accepted
//            gnt[1:0]      - one-hot grant (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
   import rotate_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic r_last;   // index of the requester granted most recently

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = r_last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (advance) begin
         r_last <= gnt[1];
      end
   end

endmodule
`default_nettype wire

// File: rtl/rotate_coef_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rotate_coef_ctrl
// Purpose  : Arbitrates two angle requesters onto the single-port cosine
//            ROM and issues two reads per transaction: cos(a) at address a,
//            then sin(a) at address a-QUARTER. Both coefficients are
//            presented together with a one-cycle coef_valid pulse.
// Ports    : clk, rst                   - clock, async active-high reset
//            reqN_valid/angle/ready     - requester N handshake (N = 0,1)
//            rom_addr, rom_rd_data      - ROM address out, ROM data in
//            coef_valid/id/cos/sin      - result pulse, owner, coefficients
//            busy                       - a transaction is in flight
// Revision : 1.0 - initial release
// ============================================================================
module rotate_coef_ctrl
   import rotate_pkg::*;
#(
   parameter int ADDR_WIDTH  = ANGLE_W,
   parameter int DATA_WIDTH  = COEF_W,
   parameter int ROM_LATENCY = 1,
   parameter int QUARTER     = rotate_pkg::QUARTER
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_angle,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_angle,
   output logic                  req1_ready,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_rd_data,
   output logic                  coef_valid,
   output logic                  coef_id,
   output logic [DATA_WIDTH-1:0] coef_cos,
   output logic [DATA_WIDTH-1:0] coef_sin,
   output logic                  busy
);

   localparam logic [ADDR_WIDTH-1:0] c_quarter   = ADDR_WIDTH'(QUARTER);
   // WAIT lasts ROM_LATENCY-1 cycles; the counter runs 0 .. c_wait_last.
   localparam logic [3:0]            c_wait_last = 4'(ROM_LATENCY - 2);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_angle;
   logic                  r_id;
   logic [ADDR_WIDTH-1:0] r_rom_addr;
   logic [3:0]            r_wait_cnt;
   logic [DATA_WIDTH-1:0] r_cos_hold;
   logic [DATA_WIDTH-1:0] r_coef_cos;
   logic [DATA_WIDTH-1:0] r_coef_sin;
   logic                  r_coef_id;
   logic                  r_coef_valid;

   logic [1:0]            w_req;
   logic [1:0]            w_gnt;
   logic                  w_idle;
   logic                  w_handshake;
   logic [ADDR_WIDTH-1:0] w_sel_angle;

   assign w_req = {req1_valid, req0_valid};

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (w_req),
      .advance (w_handshake),
      .gnt     (w_gnt)
   );

   assign w_idle = (r_state == ST_IDLE);

   // Ready is only offered in IDLE, and is held low while reset is applied
   // so no requester sees an acceptance that the registers will not take.
   assign req0_ready = w_idle & w_gnt[0] & ~rst;
   assign req1_ready = w_idle & w_gnt[1] & ~rst;

   assign w_handshake = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign w_sel_angle = w_gnt[1] ? req1_angle : req0_angle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_angle      <= '0;
         r_id         <= 1'b0;
         r_rom_addr   <= '0;
         r_wait_cnt   <= '0;
         r_cos_hold   <= '0;
         r_coef_cos   <= '0;
         r_coef_sin   <= '0;
         r_coef_id    <= 1'b0;
         r_coef_valid <= 1'b0;
      end else begin
         r_coef_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_handshake) begin
                  r_angle    <= w_sel_angle;
                  r_id       <= w_gnt[1];
                  r_rom_addr <= w_sel_angle;
                  r_state    <= ST_ADDR_COS;
               end
            end
            ST_ADDR_COS: begin
               // sin(a) = cos(a - 90 deg); 8-bit wrap gives the full-turn modulo
               r_rom_addr <= r_angle - c_quarter;
               r_state    <= ST_ADDR_SIN;
            end
            ST_ADDR_SIN: begin
               if (ROM_LATENCY == 1) begin
                  r_cos_hold <= rom_rd_data;
                  r_state    <= ST_CAP_SIN;
               end else begin
                  r_wait_cnt <= '0;
                  r_state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // cos data arrives in the final WAIT cycle
               if (r_wait_cnt == c_wait_last) begin
                  r_cos_hold <= rom_rd_data;
                  r_state    <= ST_CAP_SIN;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 4'd1;
               end
            end
            ST_CAP_SIN: begin
               // cos is staged in r_cos_hold so the visible result only
               // changes together with coef_valid
               r_coef_cos   <= r_cos_hold;
               r_coef_sin   <= rom_rd_data;
               r_coef_id    <= r_id;
               r_coef_valid <= 1'b1;
               r_state      <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rom_addr   = r_rom_addr;
   assign coef_valid = r_coef_valid;
   assign coef_id    = r_coef_id;
   assign coef_cos   = r_coef_cos;
   assign coef_sin   = r_coef_sin;
   assign busy       = ~w_idle;

endmodule
`default_nettype wire
